// File: rtl/uart_rx_core.sv
// Oversampling 8N1 UART receiver with majority-vote sampling and a small first-word-fall-through FIFO.
// Define UART_RX_PARITY_EN to add a parity bit (parity_odd selects odd/even) between data and stop.
module uart_rx_core #(
    parameter int CLK_DIV    = 27,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          ena,
    input  logic                          rxd,
`ifdef UART_RX_PARITY_EN
    input  logic                          parity_odd,
`endif
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int SAMP_W = $clog2(OVERSAMPLE);
    localparam int M      = OVERSAMPLE / 2;
    localparam int AW     = $clog2(FIFO_DEPTH);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [SAMP_W-1:0] SAMP_LO   = SAMP_W'(M - 1);
    localparam logic [SAMP_W-1:0] SAMP_MID  = SAMP_W'(M);
    localparam logic [SAMP_W-1:0] SAMP_HI   = SAMP_W'(M + 1);
    localparam logic [SAMP_W-1:0] SAMP_LAST = SAMP_W'(OVERSAMPLE - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t              state, state_nx;
    logic                sync_q, rxd_s;
    logic [DIV_W-1:0]    div_cnt;
    logic                tick;
    logic [SAMP_W-1:0]   samp;
    logic [2:0]          bit_idx;
    logic [7:0]          shift;
    logic                s_a, s_b, maj;
    logic                at_mid, at_end;
    logic                push_set, ferr_set;
    logic                push_req;
    logic [7:0]          push_data;
    logic [7:0]          mem [FIFO_DEPTH];
    logic [AW:0]         wr_ptr, rd_ptr;
    logic                pop, full;
`ifdef UART_RX_PARITY_EN
    logic                par_bad;
`endif

    assign tick   = (div_cnt == DIV_LAST);
    assign maj    = (s_a & s_b) | (s_a & rxd_s) | (s_b & rxd_s);
    assign at_mid = tick && (samp == SAMP_HI);
    assign at_end = tick && (samp == SAMP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 1'b1;
            rxd_s  <= 1'b1;
            state  <= IDLE;
        end else begin
            sync_q <= rxd;
            rxd_s  <= sync_q;
            state  <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        push_set = 1'b0;
        ferr_set = 1'b0;
        case (state)
            IDLE:  if (!rxd_s) state_nx = START;
            START: begin
                if (at_mid && maj) state_nx = IDLE;
                else if (at_end)   state_nx = DATA;
            end
`ifdef UART_RX_PARITY_EN
            DATA:   if (at_end && bit_idx == 3'd7) state_nx = PARITY;
            PARITY: if (at_end) state_nx = STOP;
            STOP: begin
                if (at_mid) begin
                    push_set = maj & ~par_bad;
                    ferr_set = ~maj | par_bad;
                    state_nx = IDLE;
                end
            end
`else
            DATA:   if (at_end && bit_idx == 3'd7) state_nx = STOP;
            STOP: begin
                if (at_mid) begin
                    push_set = maj;
                    ferr_set = ~maj;
                    state_nx = IDLE;
                end
            end
`endif
            default: state_nx = IDLE;
        endcase
        // Disabling abandons any partial frame silently
        if (!ena) begin
            state_nx = IDLE;
            push_set = 1'b0;
            ferr_set = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            samp      <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            s_a       <= 1'b1;
            s_b       <= 1'b1;
            push_req  <= 1'b0;
            push_data <= '0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad   <= 1'b0;
`endif
        end else begin
            div_cnt <= (state == IDLE || !ena || tick) ? '0 : div_cnt + DIV_W'(1);
            if (state == IDLE)
                samp <= '0;
            else if (tick)
                samp <= (samp == SAMP_LAST) ? '0 : samp + SAMP_W'(1);
            if (tick && samp == SAMP_LO)  s_a <= rxd_s;
            if (tick && samp == SAMP_MID) s_b <= rxd_s;
            if (state == START)
                bit_idx <= '0;
            else if (state == DATA && at_end)
                bit_idx <= bit_idx + 3'd1;
            if (state == DATA && at_mid)
                shift <= {maj, shift[7:1]};
`ifdef UART_RX_PARITY_EN
            if (state == PARITY && at_mid)
                par_bad <= maj ^ (^shift) ^ parity_odd;
`endif
            push_req  <= push_set;
            push_data <= shift;
            frame_err <= ferr_set;
        end
    end

    assign fifo_level = wr_ptr - rd_ptr;
    assign rx_valid   = (wr_ptr != rd_ptr);
    assign full       = (fifo_level == ($clog2(FIFO_DEPTH) + 1)'(FIFO_DEPTH));
    assign pop        = rx_valid & rx_ready;
    assign rx_data    = mem[rd_ptr[AW-1:0]];
    assign busy       = (state != IDLE);

    // A pop in the same cycle frees the slot the incoming byte needs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            overrun <= push_req && full && !pop;
            if (push_req && (!full || pop)) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr <= wr_ptr + (AW + 1)'(1);
            end
            if (pop) rd_ptr <= rd_ptr + (AW + 1)'(1);
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at CLK_DIV=2, OVERSAMPLE=16, FIFO_DEPTH=4 (32 clk per bit).
module tb_uart_rx_core;

    localparam int BIT = 32;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       rxd;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic [2:0] fifo_level;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_odd = 1'b0;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;
    int ferr_cnt  = 0;
    int ovr_cnt   = 0;

    uart_rx_core #(.CLK_DIV(2), .OVERSAMPLE(16), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .rxd        (rxd),
`ifdef UART_RX_PARITY_EN
        .parity_odd (parity_odd),
`endif
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .fifo_level (fifo_level),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_err === 1'b1) ferr_cnt++;
        if (overrun === 1'b1) ovr_cnt++;
    end

    // Called at a negedge; returns at the negedge that ends the stop bit.
    task automatic send_byte(input logic [7:0] b, input logic stop_val);
        rxd = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT) @(negedge clk);
        end
        rxd = stop_val;
        repeat (BIT) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic pop_byte(output logic [7:0] d);
        d = rx_data;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data got %h want 00", rx_data); else pass_cnt++;
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid got %b want 0", rx_valid); else pass_cnt++;
        total_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err got %b want 0", frame_err); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", overrun); else pass_cnt++;
        total_cnt++; if (fifo_level !== 3'd0) $display("FAIL reset_fifo_level got %0d want 0", fifo_level); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single();
        int lat = -1;
        int f0 = ferr_cnt;
        logic [7:0] d;
        fork
            send_byte(8'hA5, 1'b1);
            begin
                for (int n = 1; n <= 400; n++) begin
                    @(negedge clk);
                    if (lat < 0 && rx_valid === 1'b1) lat = n;
                end
            end
        join
        total_cnt++; if (lat < 296 || lat > 320) $display("FAIL single_latency got %0d want 296..320 clk", lat); else pass_cnt++;
        total_cnt++; if (rx_data !== 8'hA5) $display("FAIL single_rx_data got %h want a5", rx_data); else pass_cnt++;
        total_cnt++; if (fifo_level !== 3'd1) $display("FAIL single_level got %0d want 1", fifo_level); else pass_cnt++;
        total_cnt++; if (ferr_cnt - f0 !== 0) $display("FAIL single_frame_err got %0d want 0", ferr_cnt - f0); else pass_cnt++;
        pop_byte(d);
        total_cnt++; if (fifo_level !== 3'd0) $display("FAIL single_level_after_pop got %0d want 0", fifo_level); else pass_cnt++;
    endtask

    task automatic test_glitch();
        int f0 = ferr_cnt;
        int o0 = ovr_cnt;
        logic seen = 1'b0;
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (busy === 1'b1) seen = 1'b1;
        end
        total_cnt++; if (seen !== 1'b1) $display("FAIL glitch_busy_rise got %b want 1", seen); else pass_cnt++;
        repeat (60) @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL glitch_busy_idle got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (fifo_level !== 3'd0) $display("FAIL glitch_level got %0d want 0", fifo_level); else pass_cnt++;
        total_cnt++; if (ferr_cnt - f0 !== 0) $display("FAIL glitch_frame_err got %0d want 0", ferr_cnt - f0); else pass_cnt++;
        total_cnt++; if (ovr_cnt - o0 !== 0) $display("FAIL glitch_overrun got %0d want 0", ovr_cnt - o0); else pass_cnt++;
    endtask

    task automatic test_frame_err();
        int f0 = ferr_cnt;
        send_byte(8'h3C, 1'b0);
        repeat (60) @(negedge clk);
        total_cnt++; if (ferr_cnt - f0 !== 1) $display("FAIL ferr_pulse_cycles got %0d want 1", ferr_cnt - f0); else pass_cnt++;
        total_cnt++; if (fifo_level !== 3'd0) $display("FAIL ferr_level got %0d want 0", fifo_level); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL ferr_busy got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_overrun();
        int o0 = ovr_cnt;
        logic [7:0] d;
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
        repeat (40) @(negedge clk);
        total_cnt++; if (ovr_cnt - o0 !== 1) $display("FAIL ovr_pulse_cycles got %0d want 1", ovr_cnt - o0); else pass_cnt++;
        total_cnt++; if (fifo_level !== 3'd4) $display("FAIL ovr_level got %0d want 4", fifo_level); else pass_cnt++;
        for (int i = 1; i <= 4; i++) begin
            pop_byte(d);
            total_cnt++; if (d !== 8'(i)) $display("FAIL ovr_pop%0d got %h want %h", i, d, 8'(i)); else pass_cnt++;
        end
    endtask

    // Push of the 5th byte lands on the 312th posedge after its start edge.
    task automatic test_push_pop_full();
        int o0;
        logic [7:0] d;
        logic [7:0] exp [4] = '{8'h11, 8'h12, 8'h13, 8'h77};
        for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), 1'b1);
        repeat (20) @(negedge clk);
        o0 = ovr_cnt;
        fork
            send_byte(8'h77, 1'b1);
            begin
                repeat (311) @(posedge clk);
                @(negedge clk);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
                total_cnt++; if (fifo_level !== 3'd4) $display("FAIL pp_level got %0d want 4", fifo_level); else pass_cnt++;
            end
        join
        repeat (20) @(negedge clk);
        total_cnt++; if (ovr_cnt - o0 !== 0) $display("FAIL pp_overrun got %0d want 0", ovr_cnt - o0); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            pop_byte(d);
            total_cnt++; if (d !== exp[i]) $display("FAIL pp_pop%0d got %h want %h", i, d, exp[i]); else pass_cnt++;
        end
    endtask

    task automatic test_ena();
        int f0 = ferr_cnt;
        fork
            send_byte(8'h5A, 1'b1);
            begin
                repeat (BIT * 4) @(negedge clk);
                total_cnt++; if (busy !== 1'b1) $display("FAIL ena_busy_mid got %b want 1", busy); else pass_cnt++;
                ena = 1'b0;
                @(negedge clk);
                total_cnt++; if (busy !== 1'b0) $display("FAIL ena_busy_off got %b want 0", busy); else pass_cnt++;
            end
        join
        repeat (BIT) @(negedge clk);
        ena = 1'b1;
        repeat (5) @(negedge clk);
        send_byte(8'hC3, 1'b1);
        repeat (20) @(negedge clk);
        total_cnt++; if (fifo_level !== 3'd1) $display("FAIL ena_level got %0d want 1", fifo_level); else pass_cnt++;
        total_cnt++; if (rx_data !== 8'hC3) $display("FAIL ena_rx_data got %h want c3", rx_data); else pass_cnt++;
        total_cnt++; if (ferr_cnt - f0 !== 0) $display("FAIL ena_frame_err got %0d want 0", ferr_cnt - f0); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        rxd = 1'b0;
        repeat (100) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        total_cnt++; if (rx_data !== 8'h00) $display("FAIL arst_rx_data got %h want 00", rx_data); else pass_cnt++;
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL arst_rx_valid got %b want 0", rx_valid); else pass_cnt++;
        total_cnt++; if (fifo_level !== 3'd0) $display("FAIL arst_level got %0d want 0", fifo_level); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL arst_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (frame_err !== 1'b0) $display("FAIL arst_frame_err got %b want 0", frame_err); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL arst_overrun got %b want 0", overrun); else pass_cnt++;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL arst_busy_after got %b want 0", busy); else pass_cnt++;
    endtask

    initial begin
        rst_n    = 1'b0;
        ena      = 1'b1;
        rxd      = 1'b1;
        rx_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_glitch();
        test_frame_err();
        test_overrun();
        test_push_pop_full();
        test_ena();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Oversampling UART receiver that deserialises the external rxd line into bytes and buffers them for the UART control/interface logic.
- Consumers are uart_ctrl and the bus-side uart_interface, which turn received bytes into commands and burst data.
- Provides start-bit glitch rejection, majority-vote bit sampling, stop-bit framing check, a small receive FIFO with valid/ready output, and overrun reporting.

Parameters:
- CLK_DIV, 27: clk cycles per oversample tick. For example, 50 MHz / (115200 × 16) ≈ 27. Legal range is ≥ 1.
- OVERSAMPLE, 16: ticks per bit period. Must be even and ≥ 8.
- FIFO_DEPTH, 4: receive FIFO entries. Must be a power of 2 and ≥ 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  receiver enable, from sys_state_ctrl via uart_ena
- rxd  in  1  asynchronous serial input; idle is high
- rx_data  out  8  FIFO head byte
- rx_valid  out  1  FIFO not empty
- rx_ready  in  1  consumer accepts the head byte when rx_valid & rx_ready
- frame_err  out  1  one-cycle pulse: stop bit sampled low (or parity mismatch when the optional feature is enabled)
- overrun  out  1  one-cycle pulse: a completed byte was dropped because the FIFO was full
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- busy  out  1  receiver state machine is not in IDLE

Behaviour:
- Reset (async, rst_n low):
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, fifo_level=0, busy=0.
  - Synchroniser flops set to 1; state=IDLE; all counters cleared.
- Synchroniser: rxd passes through a 2-flop synchroniser to give rxd_s. All decisions use rxd_s.
- Tick generator:
  - div_cnt counts 0..CLK_DIV-1; tick is asserted when div_cnt==CLK_DIV-1.
  - div_cnt is held at 0 while state==IDLE, so tick phase aligns to the detected start edge.
- Sample counter: samp counts 0..OVERSAMPLE-1, advancing on tick. The bit decision is the majority of rxd_s at samp = M-1, M, M+1, where M = OVERSAMPLE/2.
- States:
  - IDLE: rxd_s==0 → START, with samp=0.
  - START: at samp==M+1, majority==1 → IDLE (glitch, no flags raised). At samp==OVERSAMPLE-1 → DATA, with bit index=0.
  - DATA: shift in the majority bit LSB-first at samp==M+1. At the last tick of bit 7 → STOP (or PARITY when the optional feature is enabled).
  - STOP: at samp==M+1:
    - majority==1 → push the byte.
    - majority==0 → pulse frame_err and discard the byte.
    - Either way → IDLE immediately, so a next start bit that arrives half a bit early is still caught.
- Push latency: the byte is written to the FIFO on the clock edge after the STOP decision. rx_valid rises on the following cycle if the FIFO was empty.
- FIFO:
  - Read and write pointers carry one wrap bit; level = wr - rd.
  - rx_data always shows the head entry (registered, first-word fall-through).
  - Pop happens on rx_valid & rx_ready.
  - Push while full with no pop → byte dropped, overrun pulses for 1 cycle, contents unchanged.
  - Push and pop in the same cycle while full → both happen, no overrun.
  - Push and pop in the same cycle while empty → push only; rx_valid is asserted next cycle.
- ena deasserted:
  - State returns to IDLE on the next clk; any partial frame is discarded with no flags raised.
  - FIFO contents are retained and stay poppable.
  - A start edge is ignored while ena==0.
- busy = (state != IDLE).
- rx_data is stable while rx_valid & !rx_ready.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, one bit period long, sampled with the same majority rule.
  - Adds input parity_odd (1 = odd parity, 0 = even).
  - On mismatch, STOP still runs; frame_err pulses at the STOP decision and the byte is discarded.
- Undefined: no PARITY state and no parity_odd port; the frame is 8N1.

Test Plan:
- CLK_DIV=2, OVERSAMPLE=16, FIFO_DEPTH=4, ena=1. Send 8N1 frame 0xA5 with rx_ready=0 → rx_valid rises about 9.5×32 clk after the start edge, rx_data=0xA5, fifo_level=1, frame_err=0.
- Low pulse on rxd of 4 clk (shorter than half a bit) → busy rises then returns to 0; no push, no flags, fifo_level=0.
- Send 0x3C with the stop bit forced low → frame_err is one 1-cycle pulse, fifo_level unchanged, state returns to IDLE.
- rx_ready=0; send 5 bytes 0x01..0x05 back-to-back → after the 5th frame overrun pulses once and fifo_level=4. Pops then return 0x01, 0x02, 0x03, 0x04.
- FIFO full (4 entries); assert rx_ready exactly in the push cycle of a 5th byte 0x77 → no overrun, fifo_level stays 4, and the last entry popped is 0x77.
- Drop ena mid-DATA of byte 0x5A, then re-enable and send 0xC3 → only 0xC3 appears, with no frame_err. Assert rst_n low mid-frame → all outputs return to their reset values asynchronously.
